pdp8_tx_arb: RTL

//  Shares one UART transmit channel (tx_req/tx_ack/tx_data/tx_empty 4-phase handshake) among N

---
 rtl/pdp8_tx_arb_pkg.sv | 11 +
 rtl/pdp8_tx_arb_rr_pick.sv | 23 ++
 rtl/pdp8_tx_arb.sv | 130 +++++++++++++
 3 files changed

// File: rtl/pdp8_tx_arb_pkg.sv
// Shared encodings for the PDP-8 UART transmit arbiter.
package pdp8_tx_arb_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_ACK   = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    localparam int TIMEOUT_DEFAULT = 4096;

endpackage

// File: rtl/pdp8_tx_arb_rr_pick.sv
// Combinational round-robin picker: first set request strictly after 'last', wrapping mod N.
module pdp8_rr_pick #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic          any,
    output logic [IW-1:0] idx
);

    always_comb begin
        any = |req;
        idx = '0;
        // Scan from the farthest candidate down so the nearest one after 'last' wins.
        for (int k = N; k >= 1; k--) begin
            if (req[(int'(last) + k) % N]) begin
                idx = IW'((int'(last) + k) % N);
            end
        end
    end

endmodule

// File: rtl/pdp8_tx_arb.sv
// Round-robin sharing of one UART transmit channel among N character sources;
// completion is reported only after the UART holding register drains.
module pdp8_tx_arb
    import pdp8_tx_arb_pkg::*;
#(
    parameter int N       = 2,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   req,
    input  logic [8*N-1:0] req_data,
    output logic [N-1:0]   grant,
    output logic [N-1:0]   done,
    output logic [N-1:0]   err,
    output logic           tx_req,
    output logic [7:0]     tx_data,
    input  logic           tx_ack,
    input  logic           tx_empty
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [IW-1:0] LAST_RST = IW'(N - 1);
    localparam logic [TW-1:0] T_LAST   = TW'(TIMEOUT - 1);
    localparam logic [N-1:0]  ONE_N    = {{(N-1){1'b0}}, 1'b1};

    logic [1:0]    state_q,   state_d;
    logic [IW-1:0] last_q,    last_d;
    logic [N-1:0]  grant_q,   grant_d;
    logic [N-1:0]  done_q,    done_d;
    logic [N-1:0]  err_q,     err_d;
    logic          tx_req_q,  tx_req_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic [TW-1:0] timer_q,   timer_d;

    logic          pick_any;
    logic [IW-1:0] pick_idx;

    pdp8_rr_pick #(.N(N), .IW(IW)) u_pick (
        .req  (req),
        .last (last_q),
        .any  (pick_any),
        .idx  (pick_idx)
    );

    // last_q doubles as the index of the source being served once granted.
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        grant_d   = grant_q;
        done_d    = '0;
        err_d     = '0;
        tx_req_d  = tx_req_q;
        tx_data_d = tx_data_q;
        timer_d   = timer_q;
        case (state_q)
            S_IDLE: begin
                // A late ack or a still-busy holding register blocks any new grant.
                if (pick_any && !tx_ack && tx_empty) begin
                    state_d   = S_REQ;
                    last_d    = pick_idx;
                    grant_d   = ONE_N << pick_idx;
                    tx_data_d = req_data[8*pick_idx +: 8];
                    timer_d   = '0;
                    tx_req_d  = 1'b1;
                end
            end
            S_REQ: begin
                if (tx_ack) begin
                    state_d  = S_ACK;
                    tx_req_d = 1'b0;
                end else if (timer_q == T_LAST) begin
                    state_d        = S_IDLE;
                    tx_req_d       = 1'b0;
                    err_d[last_q]  = 1'b1;
                    grant_d        = '0;
                end else if (timer_q != {TW{1'b1}}) begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_ACK: begin
                if (!tx_ack) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (tx_empty) begin
                    state_d        = S_IDLE;
                    done_d[last_q] = 1'b1;
                    grant_d        = '0;
                end
            end
            default: begin
                state_d  = S_IDLE;
                grant_d  = '0;
                tx_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            last_q    <= LAST_RST;
            grant_q   <= '0;
            done_q    <= '0;
            err_q     <= '0;
            tx_req_q  <= 1'b0;
            tx_data_q <= '0;
            timer_q   <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            grant_q   <= grant_d;
            done_q    <= done_d;
            err_q     <= err_d;
            tx_req_q  <= tx_req_d;
            tx_data_q <= tx_data_d;
            timer_q   <= timer_d;
        end
    end

    assign grant   = grant_q;
    assign done    = done_q;
    assign err     = err_q;
    assign tx_req  = tx_req_q;
    assign tx_data = tx_data_q;

endmodule
